// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
// Holds the FSM state enum, the no-key code and the code-width helper.
package keypad_pkg;

  typedef enum logic {
    IDLE,
    PRESSED
  } kp_state_t;

  localparam int NO_KEY = 0;

  function automatic int code_w(input int rows,
                                input int cols);
    return $clog2(rows * cols + 1);
  endfunction

endpackage

// File: rtl/keypad_code_fifo.sv
// Key-code FIFO with a valid/ready pop and a sticky overflow flag.
// Ports: push/push_code in, head_code/head_valid out, pop_req in, overflow/ovf_clr.
module keypad_code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_code,
  input  logic             pop_req,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] head_code,
  output logic             head_valid,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             empty;
  logic             full;
  logic             do_pop;
  logic             do_push;
  logic             drop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // A pop frees a slot on the same edge, so a push into a full
  // FIFO still succeeds when the head is being consumed.
  assign do_pop  = !empty && pop_req;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign head_valid = !empty;
  assign head_code  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= push_code;
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Row-strobed keypad scanner with frame debounce, ghost rejection and repeat.
// Ports: row_drv/col_in matrix, key_code/key_valid/key_ready FIFO, key_held/held_code, overflow/ovf_clr.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int  ROWS          = 4,
  parameter int  COLS          = 3,
  parameter int  SCAN_DIV      = 1000,
  parameter int  DEBOUNCE      = 4,
  parameter int  REPEAT_FRAMES = 0,
  parameter int  FIFO_DEPTH    = 4,
  localparam int CODE_W        = code_w(ROWS, COLS)
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  output logic [ROWS-1:0]   row_drv,
  input  logic [COLS-1:0]   col_in,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_held,
  output logic [CODE_W-1:0] held_code,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int ROW_W = $clog2(ROWS);
  localparam int STB_W = $clog2(DEBOUNCE + 1);
  localparam int REP_W =
    (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;

  logic [COLS-1:0]   col_s1;
  logic [COLS-1:0]   col_s2;
  logic [DIV_W-1:0]  div;
  logic [ROW_W-1:0]  row_idx;
  logic [CODE_W-1:0] acc_first;
  logic [1:0]        acc_cnt;
  logic [CODE_W-1:0] cand;
  logic [CODE_W-1:0] cand_n;
  logic [STB_W-1:0]  stable;
  logic [STB_W-1:0]  stable_n;
  logic [CODE_W-1:0] held_q;
  logic [CODE_W-1:0] held_n;
  logic [REP_W-1:0]  rep_cnt;
  logic [REP_W-1:0]  rep_n;
  kp_state_t         state;
  kp_state_t         state_n;

  logic              sample;
  logic              row_end;
  logic              frame_end;
  logic [CODE_W-1:0] row_first;
  logic [1:0]        row_cnt;
  logic [2:0]        sum3;
  logic [1:0]        tot_cnt;
  logic [CODE_W-1:0] tot_first;
  logic [CODE_W-1:0] frame_code;
  logic              is_stable;
  logic              push;
  logic [CODE_W-1:0] push_code;

  assign sample    = (div == DIV_W'(SCAN_DIV - 2));
  assign row_end   = (div == DIV_W'(SCAN_DIV - 1));
  assign frame_end = sample &&
                     (row_idx == ROW_W'(ROWS - 1));

  assign row_drv   = ROWS'(1) << row_idx;
  assign key_held  = (state == PRESSED);
  assign held_code = held_q;

  // Lowest set column of this row, plus a count saturating at 2.
  always_comb begin
    row_first = '0;
    row_cnt   = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (col_s2[c]) begin
        row_first = CODE_W'(int'(row_idx) * COLS + c + 1);
        row_cnt   = (row_cnt == 2'd2) ? 2'd2 : row_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    sum3      = {1'b0, acc_cnt} + {1'b0, row_cnt};
    tot_cnt   = (sum3 >= 3'd2) ? 2'd2 : sum3[1:0];
    tot_first = (acc_first != '0) ? acc_first : row_first;
    frame_code = (tot_cnt == 2'd1) ? tot_first : '0;
  end

  always_comb begin
    cand_n   = frame_code;
    stable_n = STB_W'(1);
    if (frame_code == cand) begin
      cand_n   = cand;
      stable_n = (stable == STB_W'(DEBOUNCE)) ?
                 stable : stable + 1'b1;
    end
    is_stable = (stable_n == STB_W'(DEBOUNCE));
  end

  always_comb begin
    state_n   = state;
    held_n    = held_q;
    rep_n     = rep_cnt;
    push      = 1'b0;
    push_code = cand_n;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (is_stable && cand_n != CODE_W'(NO_KEY)) begin
            state_n = PRESSED;
            held_n  = cand_n;
            push    = 1'b1;
            rep_n   = '0;
          end
        end
        PRESSED: begin
          if (is_stable && cand_n == CODE_W'(NO_KEY)) begin
            state_n = IDLE;
            held_n  = '0;
            rep_n   = '0;
          end else if (is_stable && cand_n != held_q) begin
            held_n = cand_n;
            push   = 1'b1;
            rep_n  = '0;
          end else if (REPEAT_FRAMES != 0) begin
            if (rep_cnt == REP_W'(REPEAT_FRAMES - 1)) begin
              push      = 1'b1;
              push_code = held_q;
              rep_n     = '0;
            end else begin
              rep_n = rep_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      col_s1    <= '0;
      col_s2    <= '0;
      div       <= '0;
      row_idx   <= '0;
      acc_first <= '0;
      acc_cnt   <= '0;
      cand      <= '0;
      stable    <= '0;
      state     <= IDLE;
      held_q    <= '0;
      rep_cnt   <= '0;
    end else begin
      col_s1 <= col_in;
      col_s2 <= col_s1;
      div    <= row_end ? '0 : div + 1'b1;
      if (row_end) begin
        row_idx <= (row_idx == ROW_W'(ROWS - 1)) ?
                   '0 : row_idx + 1'b1;
      end
      if (frame_end) begin
        acc_first <= '0;
        acc_cnt   <= '0;
        cand      <= cand_n;
        stable    <= stable_n;
      end else if (sample) begin
        acc_first <= tot_first;
        acc_cnt   <= tot_cnt;
      end
      state   <= state_n;
      held_q  <= held_n;
      rep_cnt <= rep_n;
    end
  end

  keypad_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .push       (push),
    .push_code  (push_code),
    .pop_req    (key_ready),
    .ovf_clr    (ovf_clr),
    .head_code  (key_code),
    .head_valid (key_valid),
    .overflow   (overflow)
  );

endmodule
